// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - KS10 bus field positions and responder state encoding
// Vectors are [35:0]; KS10 bit n (bit 0 = MSB) lives at index 35-n.
package mem_responder_pkg;

   localparam int BUS_W         = 36;
   localparam int ADDR_W        = 20;
   localparam int BUS_READ_BIT  = 32;
   localparam int BUS_WRITE_BIT = 30;
   localparam int BUS_IO_BIT    = 29;
   localparam int BUS_ADDR_HI   = 19;
   localparam int BUS_ADDR_LO   = 0;

   typedef enum logic [2:0] {
      sIDLE,
      sRD,
      sWR,
      sACK,
      sDONE
   } state_t;

   function automatic logic even_parity(input logic [BUS_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - KS10 memory-side responder driving a synchronous SRAM
// Optional MEM_PARITY_EN: even parity stored in SSRAM bit 36 and checked on reads.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1048576,
   parameter int unsigned RD_LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpuREQO,
   input  logic [BUS_W-1:0]  cpuADDRO,
   input  logic [BUS_W-1:0]  cpuDATAO,
   output logic              memACKO,
   output logic [BUS_W-1:0]  memDATAO,
   output logic [ADDR_W-1:0] ssramADDR,
   output logic              ssramWR,
   output logic [BUS_W:0]    ssramDOUT,
   input  logic [BUS_W:0]    ssramDIN,
   output logic              memPERR
);

   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);
   localparam logic [3:0]      LAT_INIT  = 4'(RD_LAT - 1);

   logic              bus_rd;
   logic              bus_wr;
   logic              bus_io;
   logic [ADDR_W-1:0] addr_d;
   logic              in_range;
   logic              accept;
   logic              par_d;
   logic              perr_d;
   logic              unused_addr;

   assign bus_rd   = cpuADDRO[BUS_READ_BIT];
   assign bus_wr   = cpuADDRO[BUS_WRITE_BIT];
   assign bus_io   = cpuADDRO[BUS_IO_BIT];
   assign addr_d   = cpuADDRO[BUS_ADDR_HI:BUS_ADDR_LO];
   assign in_range = {1'b0, addr_d} < MEM_LIMIT;
   assign accept   = cpuREQO & ~bus_io & in_range & (bus_rd | bus_wr);

   assign unused_addr = ^{cpuADDRO[35:33], cpuADDRO[31], cpuADDRO[28:20]};

`ifdef MEM_PARITY_EN
   assign par_d  = even_parity(cpuDATAO);
   assign perr_d = ssramDIN[BUS_W] ^ even_parity(ssramDIN[BUS_W-1:0]);
`else
   logic unused_par;
   assign par_d      = 1'b0;
   assign perr_d     = 1'b0;
   assign unused_par = ssramDIN[BUS_W];
`endif

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              ack_q;
   logic [BUS_W-1:0]  data_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BUS_W:0]    dout_q;
   logic              perr_q;

   // Strobes default low each clock so every pulse is exactly one cycle wide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= sIDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         ack_q  <= 1'b0;
         wr_q   <= 1'b0;
         perr_q <= 1'b0;
         case (state_q)
            sIDLE: begin
               if (accept) begin
                  addr_q <= addr_d;
                  dout_q <= {par_d, cpuDATAO};
                  if (bus_rd) begin
                     state_q <= sRD;
                     cnt_q   <= LAT_INIT;
                  end else begin
                     state_q <= sWR;
                     wr_q    <= 1'b1;
                  end
               end
            end
            sRD: begin
               if (cnt_q == 4'd0) begin
                  data_q  <= ssramDIN[BUS_W-1:0];
                  perr_q  <= perr_d;
                  ack_q   <= 1'b1;
                  state_q <= sACK;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            sWR: begin
               ack_q   <= 1'b1;
               state_q <= sACK;
            end
            sACK: begin
               data_q  <= '0;
               state_q <= sDONE;
            end
            sDONE: begin
               state_q <= sIDLE;
            end
            default: begin
               state_q <= sIDLE;
            end
         endcase
      end
   end

   assign memACKO   = ack_q;
   assign memDATAO  = data_q;
   assign ssramADDR = addr_q;
   assign ssramWR   = wr_q;
   assign ssramDOUT = dout_q;
   assign memPERR   = perr_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the KS10 CPU backplane bus: the target end of the memory cycles the CPU initiates.
- Decodes non-IO requests that fall in the installed memory range and drives a synchronous SRAM backend.
- Returns a one-cycle memACKO with read data. Out-of-range cycles are never acknowledged, so the CPU's NXM timeout fires.
- Sits between the CPU bus arbiter output and the SSRAM pins.

Parameters:
- MEM_WORDS, 1048576: installed words; valid addresses are 0 to MEM_WORDS-1.
- RD_LAT, 2: SSRAM read latency in clocks. Legal range 1..12, so ACK lands well inside the CPU's 15-clock NXM window.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- cpuREQO, input, 1: bus request; held by CPU until ACK.
- cpuADDRO, input, 36: bus address word. Flags plus address [16:35].
- cpuDATAO, input, 36: write data.
- memACKO, output, 1: one-cycle acknowledge.
- memDATAO, output, 36: read data, valid while memACKO=1, else 0.
- ssramADDR, output, 20: SSRAM word address.
- ssramWR, output, 1: SSRAM write strobe.
- ssramDOUT, output, 37: SSRAM write data. Bit 36 is parity.
- ssramDIN, input, 37: SSRAM read data.
- memPERR, output, 1: one-cycle read-parity error pulse.

Behaviour:
- Decode uses the shared bus flag macros: busREAD, busWRITE, busIO; address is cpuADDRO[16:35].
- Request accepted in IDLE when: cpuREQO & !busIO & (addr < MEM_WORDS) & (busREAD | busWRITE).
- Anything else in IDLE (IO, out of range, no R/W flag): ignored, no ACK, state stays IDLE.
- States:
  - IDLE → RD if busREAD (READ wins when both flags are set, i.e. RMW-read half); → WR if busWRITE only.
  - RD: wait counter, 4 bits, loaded with RD_LAT-1 on entry. When counter=0, latch ssramDIN and go to ACK.
  - WR: ssramWR=1 for exactly one cycle, then go to ACK.
  - ACK: memACKO=1 for one cycle. memDATAO = latched data on reads, 0 on writes. Next state DONE.
  - DONE: one-cycle hold-off so the still-asserted cpuREQO is not re-accepted. Next state IDLE.
- ssramADDR and write data are registered at acceptance and held stable until DONE.
- Latency, with the request sampled at edge 0:
  - Read: ACK in cycle 1+RD_LAT (default: cycle 3).
  - Write: ACK in cycle 2.
  - Back-to-back requests accepted no earlier than 2 cycles after ACK.
- cpuREQO dropping mid-cycle does not abort. The access completes and ACK is still issued.
- Address wrap: ssramADDR is plain truncation of [16:35]. The range check prevents aliasing when MEM_WORDS < 2^20.
- Reset (rst=0, asynchronous), effective immediately even mid-access:
  - state=IDLE, counter=0.
  - memACKO=0, memDATAO=0, ssramWR=0, ssramADDR=0, ssramDOUT=0, memPERR=0.
  - An in-flight access is abandoned with no ACK.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Writes store even parity of cpuDATAO[0:35] in ssramDOUT[36].
  - At read latch time, a mismatch pulses memPERR together with memACKO. Data is still returned.
- Undefined:
  - ssramDOUT[36]=0, ssramDIN[36] ignored, memPERR tied 0.

Decomposition:
- Shared bus header: flag macros busREAD, busWRITE, busIO and the address field bounds [16:35]. Already in shared bus.vh; reuse, do not redefine.
- Local: state encodings localparam sIDLE, sRD, sWR, sACK, sDONE.
- No sub-module needed. Parity is a single XOR reduction inline.

Test Plan:
- Write then read: write addr 0o001234 data 0o123456701234. ACK in cycle 2 with ssramWR pulse of 1 cycle. Read same addr with RD_LAT=2: ACK in cycle 3, memDATAO=0o123456701234.
- Out of range: MEM_WORDS=262144, read addr 0o1000000. No memACKO in 20 cycles, ssramWR never asserted.
- IO cycle: busIO=1 with READ, addr 0o000100. No ACK, state remains IDLE.
- Held request: cpuREQO held 10 cycles after ACK. Exactly one ACK per accepted request. Second ACK appears only for a new request after DONE.
- Async reset mid-read: drop rst one cycle after acceptance. All outputs 0 immediately, no ACK. After release, a fresh read completes normally.
- MEM_PARITY_EN: force ssramDIN[36] wrong on read. memPERR=1 in the same cycle as memACKO. With the macro undefined, memPERR stays 0.
